// File: rtl/ram_sdp_flagged_if.sv
// Bus bundle for ram_sdp_flagged: write/read requests plus registered status.
interface ram_sdp_flagged_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IN_W   = 128,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
  logic [ADDR_W-1:0] write_addr;
  logic [ADDR_W-1:0] read_addr;
  logic [IN_W-1:0]   input_data;
  logic              read_enable;
  logic              write_enable;
  logic [DATA_W-1:0] read_out;
  logic              read_valid;
  logic              invalid_r_addr;
  logic              invalid_w_addr;
  logic              w_r_same_addr;
  logic              mem_loc_occupied;
  logic              data_overflow;
  logic [CNT_W-1:0]  occupied_count;
  logic              full;
  logic              empty;

  modport master (
    output write_addr, read_addr, input_data, read_enable, write_enable,
    input  read_out, read_valid, invalid_r_addr, invalid_w_addr, w_r_same_addr,
           mem_loc_occupied, data_overflow, occupied_count, full, empty
  );

  modport slave (
    input  write_addr, read_addr, input_data, read_enable, write_enable,
    output read_out, read_valid, invalid_r_addr, invalid_w_addr, w_r_same_addr,
           mem_loc_occupied, data_overflow, occupied_count, full, empty
  );
endinterface

// File: rtl/ram_sdp_flagged.sv
// Simple dual-port RAM with per-word valid bits, occupancy counter and
// registered single-cycle error flags.
// Define RAM_WR_BYPASS_EN to turn a same-address read/write into a write
// with read-through of the incoming data instead of a suppressed conflict.
module ram_sdp_flagged #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IN_W   = 128,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  ram_sdp_flagged_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] read_out_q, read_out_d;
  logic              read_valid_q, read_valid_d;
  logic [4:0]        flags_q, flags_d;  // {inv_r, inv_w, same, occ, ovf}

  logic [IdxW-1:0]       widx, ridx;
  logic [IN_W-DATA_W:0]  sign_bits;
  logic                  wa_ok, ra_ok, ovf, conf, wr_acc, rd_acc, conf_flag, old_valid;
  logic [DATA_W-1:0]     rd_data;

  assign widx      = bus.write_addr[IdxW-1:0];
  assign ridx      = bus.read_addr[IdxW-1:0];
  // Full-width compare so out-of-range addresses never alias into the array.
  assign wa_ok     = bus.write_addr < ADDR_W'(DEPTH);
  assign ra_ok     = bus.read_addr < ADDR_W'(DEPTH);
  assign sign_bits = bus.input_data[IN_W-1:DATA_W-1];
  assign ovf       = !((&sign_bits) || !(|sign_bits));
  assign conf      = bus.write_enable & bus.read_enable & wa_ok & ra_ok &
                     (bus.write_addr == bus.read_addr);

  // Access acceptance and read data selection.
  always_comb begin
`ifdef RAM_WR_BYPASS_EN
    wr_acc    = bus.write_enable & wa_ok & !ovf;
    rd_acc    = bus.read_enable & ra_ok;
    conf_flag = 1'b0;
`else
    wr_acc    = bus.write_enable & wa_ok & !ovf & !conf;
    rd_acc    = bus.read_enable & ra_ok & !conf;
    conf_flag = conf;
`endif
    old_valid = wa_ok & valid_q[widx];
    rd_data   = valid_q[ridx] ? mem_q[ridx] : '0;
`ifdef RAM_WR_BYPASS_EN
    // Overflowing write is dropped, so the read then sees the stored word.
    if (conf && !ovf) rd_data = bus.input_data[DATA_W-1:0];
`endif
  end

  // Next-state for valid bits, counter, read port and flags.
  always_comb begin
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    read_out_d   = read_out_q;
    read_valid_d = rd_acc;
    if (wr_acc) begin
      valid_d[widx] = 1'b1;
      if (!old_valid) cnt_d = cnt_q + CNT_W'(1);
    end
    if (rd_acc) read_out_d = rd_data;
    flags_d = {bus.read_enable & !ra_ok,
               bus.write_enable & !wa_ok,
               conf_flag,
               wr_acc & old_valid,
               bus.write_enable & wa_ok & ovf};
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      cnt_q        <= '0;
      read_out_q   <= '0;
      read_valid_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      read_out_q   <= read_out_d;
      read_valid_q <= read_valid_d;
      flags_q      <= flags_d;
    end
  end

  // Storage array is not reset; cleared valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[widx] <= bus.input_data[DATA_W-1:0];
  end

  assign bus.read_out         = read_out_q;
  assign bus.read_valid       = read_valid_q;
  assign bus.invalid_r_addr   = flags_q[4];
  assign bus.invalid_w_addr   = flags_q[3];
  assign bus.w_r_same_addr    = flags_q[2];
  assign bus.mem_loc_occupied = flags_q[1];
  assign bus.data_overflow    = flags_q[0];
  assign bus.occupied_count   = cnt_q;
  assign bus.full             = cnt_q == CNT_W'(DEPTH);
  assign bus.empty            = cnt_q == '0;

endmodule

// File: tb/tb_ram_sdp_flagged.sv
// Directed table-driven bench for ram_sdp_flagged (default parameters).
module tb_ram_sdp_flagged;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_sdp_flagged_if bus ();

  ram_sdp_flagged dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          we;
    logic [63:0]   wa;
    logic          re;
    logic [63:0]   ra;
    logic [127:0]  din;
    logic          rv;
    logic [63:0]   rout;
    logic [4:0]    flags;  // {inv_r, inv_w, same, occ, ovf}
    int unsigned   cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[17];

  localparam logic [63:0] Neg5 = 64'hFFFF_FFFF_FFFF_FFFB;

  function automatic vec_t mk(logic we, logic [63:0] wa, logic re, logic [63:0] ra,
                              logic [127:0] din, logic rv, logic [63:0] rout,
                              logic [4:0] flags, int unsigned cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.re = re; v.ra = ra; v.din = din;
    v.rv = rv; v.rout = rout; v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [63:0] wa, logic re, logic [63:0] ra, logic [127:0] din);
    bus.write_enable = we;
    bus.write_addr   = wa;
    bus.read_enable  = re;
    bus.read_addr    = ra;
    bus.input_data   = din;
  endtask

  task automatic chk_state(string tag, logic rv, logic [63:0] rout, logic [4:0] flags,
                           int unsigned cnt);
    chk($sformatf("%s.read_valid", tag), 128'(bus.read_valid), 128'(rv));
    chk($sformatf("%s.read_out", tag), 128'(bus.read_out), 128'(rout));
    chk($sformatf("%s.flags", tag),
        128'({bus.invalid_r_addr, bus.invalid_w_addr, bus.w_r_same_addr,
              bus.mem_loc_occupied, bus.data_overflow}), 128'(flags));
    chk($sformatf("%s.count", tag), 128'(bus.occupied_count), 128'(cnt));
    chk($sformatf("%s.full", tag), 128'(bus.full), 128'(cnt == 32));
    chk($sformatf("%s.empty", tag), 128'(bus.empty), 128'(cnt == 0));
  endtask

  initial begin
    vecs[0]  = mk(1, 2, 0, 0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 0, 0, 5'b00001, 0);
    vecs[1]  = mk(1, 2, 0, 0, 128'd7, 0, 0, 5'b00000, 1);
    vecs[2]  = mk(0, 0, 1, 5, 128'd0, 1, 0, 5'b00000, 1);
    vecs[3]  = mk(0, 0, 1, 2, 128'd0, 1, 7, 5'b00000, 1);
    vecs[4]  = mk(1, 40, 0, 0, 128'd1, 0, 7, 5'b01000, 1);
    vecs[5]  = mk(0, 0, 1, 33, 128'd0, 0, 7, 5'b10000, 1);
`ifdef RAM_WR_BYPASS_EN
    vecs[6]  = mk(1, 2, 1, 2, 128'd9, 1, 9, 5'b00010, 1);
    vecs[7]  = mk(0, 0, 1, 2, 128'd0, 1, 9, 5'b00000, 1);
    vecs[8]  = mk(1, 2, 0, 0, 128'd11, 0, 9, 5'b00010, 1);
`else
    vecs[6]  = mk(1, 2, 1, 2, 128'd9, 0, 7, 5'b00100, 1);
    vecs[7]  = mk(0, 0, 1, 2, 128'd0, 1, 7, 5'b00000, 1);
    vecs[8]  = mk(1, 2, 0, 0, 128'd11, 0, 7, 5'b00010, 1);
`endif
    vecs[9]  = mk(0, 0, 1, 2, 128'd0, 1, 11, 5'b00000, 1);
    vecs[10] = mk(1, 3, 1, 2, {64'hFFFF_FFFF_FFFF_FFFF, Neg5}, 1, 11, 5'b00000, 2);
    vecs[11] = mk(0, 0, 1, 3, 128'd0, 1, Neg5, 5'b00000, 2);
    vecs[12] = mk(1, 4, 1, 3, {64'h0, 64'h8000_0000_0000_0000}, 1, Neg5, 5'b00001, 2);
    vecs[13] = mk(1, 4, 1, 100, 128'd5, 0, Neg5, 5'b10000, 3);
    vecs[14] = mk(1, 31, 0, 0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
                  0, Neg5, 5'b00000, 4);
    vecs[15] = mk(1, 32, 0, 0, 128'd1, 0, Neg5, 5'b01000, 4);
    vecs[16] = mk(1, 64'h1_0000_0005, 1, 64'h1_0000_0002, 128'd1, 0, Neg5, 5'b11000, 4);

    // Reset state
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 5'b00000, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].re, vecs[i].ra, vecs[i].din);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rout, vecs[i].flags, vecs[i].cnt);
    end

    // Fill every location; only previously empty words add to the count.
    for (int a = 0; a < 32; a++) begin
      drive(1, 64'(a), 0, 0, 128'(a + 100));
      @(posedge clk);
      #1;
    end
    chk_state("fill", 0, Neg5, 5'b00010, 32);

    drive(0, 0, 1, 2, 0);
    @(posedge clk);
    #1;
    chk_state("fill_read", 1, 64'd102, 5'b00000, 32);

    // Asynchronous reset between edges with a read still requested.
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 5'b00000, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_rst_read", 1, 0, 5'b00000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
